uart_mmio_controller: RTL and testbench
=======================================

UART_MMIO_CONTROLLER -- requirements
Module: uart_mmio_controller

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, the bus data/address width.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h1001_0024, the UART TX-data address.
REQ-003 SHALL have port clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port Address  input  DATA_WIDTH  CPU bus address.
REQ-006 SHALL have port Mem_Write  input  1  CPU store strobe, one cycle per store.
REQ-007 SHALL have port Mem_Read  input  1  CPU load strobe, one cycle per load.
REQ-008 SHALL have port Write_Data  input  DATA_WIDTH  CPU store data.
REQ-009 SHALL have port Tx_Busy  input  1  UART transmitter busy level.
REQ-010 SHALL have port Rx_Valid  input  1  one-cycle pulse: received byte on Rx_Data.
REQ-011 SHALL have port Rx_Data  input  8  received byte.
REQ-012 SHALL have port Device_Select  output  2  select code to the register/device read mux.
REQ-013 SHALL have port Device_Data  output  DATA_WIDTH  device read data, the mux's device input.
REQ-014 SHALL have port Tx_Start  output  1  one-cycle transmit start pulse.
REQ-015 SHALL have port Tx_Data  output  8  byte to transmit, held stable while sending.

Function
REQ-016 SHALL decode Address combinationally, independent of strobes: BASE_ADDR -> 2'b01 (TX data), BASE_ADDR+4 -> 2'b10 (RX data), BASE_ADDR+8 -> 2'b11 (status), any other address -> 2'b00.
REQ-017 SHALL drive Device_Data combinationally: 01 -> zero-extended Tx_Data; 10 -> zero-extended RX holding byte; 11 -> {zeros, overrun, rx_full, tx_busy} in bits [2:0]; 00 -> all zeros.
REQ-018 SHALL implement TX FSM states TX_IDLE, TX_START, TX_WAIT, TX_BUSY.
REQ-019 In TX_IDLE, Mem_Write with select 01 SHALL latch Write_Data[7:0] into Tx_Data and go to TX_START; Write_Data[DATA_WIDTH-1:8] is ignored.
REQ-020 TX_START SHALL assert Tx_Start for exactly one cycle, then go to TX_WAIT.
REQ-021 TX_WAIT SHALL go to TX_BUSY when Tx_Busy=1; if Tx_Busy stays 0 for 16 cycles it SHALL return to TX_IDLE (lost-start timeout).
REQ-022 TX_BUSY SHALL return to TX_IDLE on the first cycle Tx_Busy=0.
REQ-023 tx_busy status SHALL be 1 in every state except TX_IDLE; TX-data writes outside TX_IDLE SHALL be dropped, leaving Tx_Data unchanged.
REQ-024 Rx_Valid SHALL latch Rx_Data into the RX holding register and set rx_full at the same edge.
REQ-025 Mem_Read with select 10 SHALL clear rx_full at that cycle's edge; read data is the pre-edge value.
REQ-026 Rx_Valid while rx_full=1 with no same-cycle RX read SHALL overwrite the byte and set sticky overrun.
REQ-027 Simultaneous Rx_Valid and RX read SHALL capture the new byte, leave rx_full=1, and not set overrun.
REQ-028 Mem_Write with select 11 and Write_Data[2]=1 SHALL clear overrun; other status bits are read-only.
REQ-029 Mem_Read SHALL never change TX state, and reads of addresses with select 00 or 01 SHALL have no side effects.

Reset
REQ-030 Asserting reset SHALL immediately force the TX FSM to TX_IDLE, clear Tx_Start, Tx_Data, the RX holding register, rx_full and overrun to 0, aborting any transfer in progress; Device_Select and Device_Data remain pure functions of Address and register state.

Verification
REQ-031 Store 0x0000_0041 to BASE_ADDR -> next cycle Tx_Start=1 for one cycle, Tx_Data=0x41; hold Tx_Busy=1 for 10 cycles -> status reads 0x1 until Tx_Busy falls, then 0x0.
REQ-032 Second store of 0x42 while Tx_Busy=1 -> no Tx_Start, Tx_Data stays 0x41.
REQ-033 Rx_Valid with 0x5A -> status 0x2, RX read returns 0x5A, then status 0x0; two pulses (0x11, 0x22) without a read -> status 0x6, RX read returns 0x22; status store with 0x4 -> status 0x0.
REQ-034 Rx_Valid (0x33) in the same cycle as an RX read -> status reads 0x2, no overrun, next RX read returns 0x33.
REQ-035 Store to BASE_ADDR, Tx_Busy held 0 -> returns to TX_IDLE 16 cycles after TX_WAIT entry; reset asserted mid-TX_BUSY -> all status bits 0 immediately; Address=BASE_ADDR+12 -> Device_Select=00, Device_Data=0.

Source files
------------

// File: rtl/uart_mmio_controller.sv
// Memory-mapped UART front end: decodes TX-data/RX-data/status registers on the CPU
// bus, sequences transmit starts against the transmitter's busy level, holds received bytes.
module uart_mmio_controller #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] BASE_ADDR  = 32'h1001_0024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] Address,
    input  logic                  Mem_Write,
    input  logic                  Mem_Read,
    input  logic [DATA_WIDTH-1:0] Write_Data,
    input  logic                  Tx_Busy,
    input  logic                  Rx_Valid,
    input  logic [7:0]            Rx_Data,
    output logic [1:0]            Device_Select,
    output logic [DATA_WIDTH-1:0] Device_Data,
    output logic                  Tx_Start,
    output logic [7:0]            Tx_Data
);

    localparam logic [DATA_WIDTH-1:0] RX_ADDR   = BASE_ADDR + DATA_WIDTH'(4);
    localparam logic [DATA_WIDTH-1:0] STAT_ADDR = BASE_ADDR + DATA_WIDTH'(8);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_WAIT, TX_BUSY} tx_state_t;

    tx_state_t  tx_state;
    logic [3:0] wait_cnt;
    logic [7:0] rx_byte;
    logic       rx_full;
    logic       overrun;
    logic       tx_busy;
    logic       rx_read;
    logic       ovr_clr;

    // Only the low byte of a TX store is meaningful.
    wire unused_wd_hi = ^Write_Data[DATA_WIDTH-1:8];

    always_comb begin
        Device_Select = 2'b00;
        if (Address == BASE_ADDR)      Device_Select = 2'b01;
        else if (Address == RX_ADDR)   Device_Select = 2'b10;
        else if (Address == STAT_ADDR) Device_Select = 2'b11;
    end

    assign tx_busy = (tx_state != TX_IDLE);
    assign rx_read = Mem_Read  && (Device_Select == 2'b10);
    assign ovr_clr = Mem_Write && (Device_Select == 2'b11) && Write_Data[2];

    always_comb begin
        Device_Data = '0;
        case (Device_Select)
            2'b01:   Device_Data[7:0] = Tx_Data;
            2'b10:   Device_Data[7:0] = rx_byte;
            2'b11:   Device_Data[2:0] = {overrun, rx_full, tx_busy};
            default: Device_Data = '0;
        endcase
    end

    // TX_WAIT gives the transmitter 16 cycles to raise busy before the start is deemed lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_state <= TX_IDLE;
            Tx_Start <= 1'b0;
            Tx_Data  <= 8'h00;
            wait_cnt <= 4'd0;
        end else begin
            Tx_Start <= 1'b0;
            case (tx_state)
                TX_IDLE: if (Mem_Write && Device_Select == 2'b01) begin
                    Tx_Data  <= Write_Data[7:0];
                    Tx_Start <= 1'b1;
                    tx_state <= TX_START;
                end
                TX_START: begin
                    wait_cnt <= 4'd0;
                    tx_state <= TX_WAIT;
                end
                TX_WAIT: begin
                    if (Tx_Busy)               tx_state <= TX_BUSY;
                    else if (wait_cnt == 4'd15) tx_state <= TX_IDLE;
                    else                        wait_cnt <= wait_cnt + 4'd1;
                end
                TX_BUSY: if (!Tx_Busy) tx_state <= TX_IDLE;
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    // A new byte beats a same-cycle read: the read consumes the old byte, the new one stays held.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_byte <= 8'h00;
            rx_full <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (Rx_Valid) begin
                rx_byte <= Rx_Data;
                rx_full <= 1'b1;
            end else if (rx_read) begin
                rx_full <= 1'b0;
            end
            if (Rx_Valid && rx_full && !rx_read) overrun <= 1'b1;
            else if (ovr_clr)                    overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_mmio_controller.sv
// Scoreboard bench: stimulus pushes expected read data and transmit bytes; a negedge
// monitor pops them whenever the controller presents a read or a Tx_Start pulse.
module tb_uart_mmio_controller;

    localparam logic [31:0] BASE = 32'h1001_0024;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] Address = '0;
    logic        Mem_Write = 1'b0;
    logic        Mem_Read = 1'b0;
    logic [31:0] Write_Data = '0;
    logic        Tx_Busy = 1'b0;
    logic        Rx_Valid = 1'b0;
    logic [7:0]  Rx_Data = '0;
    logic [1:0]  Device_Select;
    logic [31:0] Device_Data;
    logic        Tx_Start;
    logic [7:0]  Tx_Data;

    uart_mmio_controller dut (
        .clk(clk), .reset(reset), .Address(Address), .Mem_Write(Mem_Write),
        .Mem_Read(Mem_Read), .Write_Data(Write_Data), .Tx_Busy(Tx_Busy),
        .Rx_Valid(Rx_Valid), .Rx_Data(Rx_Data), .Device_Select(Device_Select),
        .Device_Data(Device_Data), .Tx_Start(Tx_Start), .Tx_Data(Tx_Data)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    logic [33:0] rd_q[$];
    logic [7:0]  tx_q[$];

    // Reference model: register contents plus a coarse view of the transmit transaction.
    logic [7:0] m_tx_data, m_rx_byte;
    bit m_full, m_ovr, m_inflight, m_start_now, m_got_busy;
    int m_waited;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic model_reset();
        m_tx_data = 0; m_rx_byte = 0; m_full = 0; m_ovr = 0;
        m_inflight = 0; m_start_now = 0; m_got_busy = 0; m_waited = 0;
    endtask

    function automatic logic [33:0] m_read(input logic [31:0] a);
        if (a == BASE)     return {2'b01, 24'h0, m_tx_data};
        if (a == BASE + 4) return {2'b10, 24'h0, m_rx_byte};
        if (a == BASE + 8) return {2'b11, 29'h0, m_ovr, m_full, m_inflight};
        return 34'h0;
    endfunction

    task automatic model_edge(input logic [31:0] a, input bit wr, input bit rd,
                              input logic [31:0] wd, input bit busy, input bit rxv,
                              input logic [7:0] rxd);
        bit rxread;
        rxread = rd && (a == BASE + 4);
        if (wr && a == BASE + 8 && wd[2]) m_ovr = 0;
        if (rxv) begin
            if (m_full && !rxread) m_ovr = 1;
            m_rx_byte = rxd;
            m_full = 1;
        end else if (rxread) m_full = 0;

        if (m_start_now) begin
            m_start_now = 0; m_waited = 0; m_got_busy = 0;
        end else if (m_inflight) begin
            if (!m_got_busy) begin
                if (busy) m_got_busy = 1;
                else begin
                    m_waited++;
                    if (m_waited == 16) m_inflight = 0;
                end
            end else if (!busy) m_inflight = 0;
        end else if (wr && a == BASE) begin
            m_tx_data = wd[7:0];
            m_inflight = 1;
            m_start_now = 1;
            tx_q.push_back(wd[7:0]);
        end
    endtask

    // One bus cycle; use_exp replaces the model's read prediction with a fixed expected value.
    task automatic step(input logic [31:0] a, input bit wr, input bit rd, input logic [31:0] wd,
                        input bit busy, input bit rxv, input logic [7:0] rxd,
                        input bit use_exp, input logic [33:0] exp);
        @(posedge clk);
        #1;
        Address = a; Mem_Write = wr; Mem_Read = rd; Write_Data = wd;
        Tx_Busy = busy; Rx_Valid = rxv; Rx_Data = rxd;
        if (rd) rd_q.push_back(use_exp ? exp : m_read(a));
        model_edge(a, wr, rd, wd, busy, rxv, rxd);
    endtask

    task automatic rd_chk(input logic [31:0] a, input logic [33:0] exp, input bit busy);
        step(a, 0, 1, 0, busy, 0, 0, 1, exp);
    endtask
    task automatic wr(input logic [31:0] a, input logic [31:0] wd, input bit busy);
        step(a, 1, 0, wd, busy, 0, 0, 0, 0);
    endtask
    task automatic rx(input logic [7:0] b);
        step(BASE + 12, 0, 0, 0, 0, 1, b, 0, 0);
    endtask
    task automatic idle(input bit busy);
        step(32'h0, 0, 0, 0, busy, 0, 0, 0, 0);
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (Mem_Read) begin
                if (rd_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL read: response with no expectation queued");
                end else check("read {sel,data}", {30'h0, Device_Select, Device_Data}, {30'h0, rd_q.pop_front()});
            end
            if (Tx_Start) begin
                if (tx_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL tx_start: unexpected pulse, Tx_Data=%h", Tx_Data);
                end else check("tx_data at start", {56'h0, Tx_Data}, {56'h0, tx_q.pop_front()});
            end
        end
    end

    initial begin
        logic [31:0] a;
        bit busy;
        model_reset();
        Address = BASE + 8;
        #12;
        check("reset status", {32'h0, Device_Data}, 64'h0);
        check("reset select", {62'h0, Device_Select}, 64'h3);
        check("reset tx_start", {63'h0, Tx_Start}, 64'h0);
        check("reset tx_data", {56'h0, Tx_Data}, 64'h0);
        @(posedge clk); #2 reset = 1'b0;

        // Store 0x41, transmitter busy for 10 cycles; a second store while busy is dropped.
        wr(BASE, 32'h0000_0041, 0);
        for (int i = 1; i <= 10; i++) begin
            if (i == 5) wr(BASE, 32'hABCD_EF42, 1);
            else rd_chk(BASE + 8, {2'b11, 32'h1}, 1);
        end
        rd_chk(BASE + 8, {2'b11, 32'h1}, 0);
        rd_chk(BASE + 8, {2'b11, 32'h0}, 0);
        rd_chk(BASE, {2'b01, 32'h41}, 0);

        // RX hold, read-clear, overrun and its clear.
        rx(8'h5A);
        rd_chk(BASE + 8, {2'b11, 32'h2}, 0);
        rd_chk(BASE + 4, {2'b10, 32'h5A}, 0);
        rd_chk(BASE + 8, {2'b11, 32'h0}, 0);
        rx(8'h11);
        rx(8'h22);
        rd_chk(BASE + 8, {2'b11, 32'h6}, 0);
        rd_chk(BASE + 4, {2'b10, 32'h22}, 0);
        wr(BASE + 8, 32'h4, 0);
        rd_chk(BASE + 8, {2'b11, 32'h0}, 0);

        // Byte arriving on the same cycle as a read of the previous one.
        rx(8'h77);
        step(BASE + 4, 0, 1, 0, 0, 1, 8'h33, 1, {2'b10, 32'h77});
        rd_chk(BASE + 8, {2'b11, 32'h2}, 0);
        rd_chk(BASE + 4, {2'b10, 32'h33}, 0);

        // Lost start: busy never rises, FSM gives up 16 cycles after entering wait.
        wr(BASE, 32'h55, 0);
        for (int i = 1; i <= 17; i++) rd_chk(BASE + 8, {2'b11, 32'h1}, 0);
        rd_chk(BASE + 8, {2'b11, 32'h0}, 0);
        rd_chk(BASE + 12, 34'h0, 0);

        // Reset in the middle of a busy transfer with RX full and overrun set.
        rx(8'h01);
        rx(8'h02);
        wr(BASE, 32'h66, 0);
        for (int i = 0; i < 4; i++) idle(1);
        @(posedge clk); #2;
        Address = BASE + 8; Mem_Write = 0; Mem_Read = 0; Rx_Valid = 0;
        reset = 1'b1;
        #1;
        check("mid-transfer reset status", {32'h0, Device_Data}, 64'h0);
        check("mid-transfer reset tx_data", {56'h0, Tx_Data}, 64'h0);
        Address = BASE + 4;
        #1;
        check("mid-transfer reset rx byte", {32'h0, Device_Data}, 64'h0);
        model_reset();
        @(posedge clk); #2 reset = 1'b0;
        Tx_Busy = 0;

        // Randomized traffic against the model.
        busy = 0;
        for (int i = 0; i < 2500; i++) begin
            case ($urandom_range(4))
                0: a = BASE;
                1: a = BASE + 4;
                2: a = BASE + 8;
                3: a = BASE + 12;
                default: a = $urandom;
            endcase
            if ($urandom_range(7) == 0) busy = !busy;
            step(a, $urandom_range(7) == 0, $urandom_range(3) == 0, $urandom, busy,
                 $urandom_range(9) == 0, 8'($urandom), 0, 0);
        end
        for (int i = 0; i < 24; i++) idle(0);
        rd_chk(BASE + 8, {2'b11, 29'h0, m_ovr, m_full, 1'b0}, 0);
        idle(0);
        @(negedge clk);
        check("pending tx starts", 64'(tx_q.size()), 64'h0);
        check("pending reads", 64'(rd_q.size()), 64'h0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
